// File: rtl/gc_axil_initiator.sv
// gc_axil_initiator
// Single-outstanding AXI4-Lite initiator for the Garnet control port. One command in, one
// AW/W/B or AR/R transaction out, one response back. Each handshake phase has a cycle budget;
// when it runs out, all channel valids/readies drop and a timeout response is returned so a
// hung responder cannot stall the caller.
//
// TIMEOUT must be at least 2.

module gc_axil_initiator #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    clk,
  input  logic                    reset,

  // Command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  // Response side
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic                    rsp_timeout,

  // Write address channel
  output logic [ADDR_WIDTH-1:0]   gc_awaddr,
  output logic                    gc_awvalid,
  input  logic                    gc_awready,

  // Write data channel
  output logic [DATA_WIDTH-1:0]   gc_wdata,
  output logic [DATA_WIDTH/8-1:0] gc_wstrb,
  output logic                    gc_wvalid,
  input  logic                    gc_wready,

  // Write response channel (single-bit bresp, as on the Garnet top)
  input  logic                    gc_bvalid,
  input  logic                    gc_bresp,
  output logic                    gc_bready,

  // Read address channel
  output logic [ADDR_WIDTH-1:0]   gc_araddr,
  output logic                    gc_arvalid,
  input  logic                    gc_arready,

  // Read data channel
  input  logic [DATA_WIDTH-1:0]   gc_rdata,
  input  logic [1:0]              gc_rresp,
  input  logic                    gc_rvalid,
  output logic                    gc_rready
);

  localparam int unsigned StrbWidth = DATA_WIDTH / 8;
  localparam int unsigned CntWidth  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntWidth-1:0] CntLast = CntWidth'(TIMEOUT - 1);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StWrAwW = 3'd1;
  localparam logic [2:0] StWrB   = 3'd2;
  localparam logic [2:0] StRdAr  = 3'd3;
  localparam logic [2:0] StRdR   = 3'd4;
  localparam logic [2:0] StRsp   = 3'd5;

  localparam logic [1:0] RespSlvErr = 2'b10;

  logic [2:0]            state_q,       state_d;
  logic [CntWidth-1:0]   cnt_q,         cnt_d;
  logic                  cmd_ready_q,   cmd_ready_d;
  logic                  awvalid_q,     awvalid_d;
  logic                  wvalid_q,      wvalid_d;
  logic                  bready_q,      bready_d;
  logic                  arvalid_q,     arvalid_d;
  logic                  rready_q,      rready_d;
  logic                  rsp_valid_q,   rsp_valid_d;
  logic [ADDR_WIDTH-1:0] awaddr_q,      awaddr_d;
  logic [ADDR_WIDTH-1:0] araddr_q,      araddr_d;
  logic [DATA_WIDTH-1:0] wdata_q,       wdata_d;
  logic [StrbWidth-1:0]  wstrb_q,       wstrb_d;
  logic [DATA_WIDTH-1:0] rsp_rdata_q,   rsp_rdata_d;
  logic [1:0]            rsp_resp_q,    rsp_resp_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  logic accept;
  logic phase_expired;
  logic aw_w_complete;
  logic abort;

  assign accept        = cmd_valid & cmd_ready_q;
  assign phase_expired = (cnt_q == CntLast);
  // A channel whose valid has already dropped is done; otherwise it completes on ready.
  assign aw_w_complete = (~awvalid_q | gc_awready) & (~wvalid_q | gc_wready);

  // Next-state, channel controls and response capture.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    awvalid_d     = awvalid_q;
    wvalid_d      = wvalid_q;
    bready_d      = bready_q;
    arvalid_d     = arvalid_q;
    rready_d      = rready_q;
    rsp_valid_d   = rsp_valid_q;
    awaddr_d      = awaddr_q;
    araddr_d      = araddr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_resp_d    = rsp_resp_q;
    rsp_timeout_d = rsp_timeout_q;
    abort         = 1'b0;

    case (state_q)
      StIdle: begin
        if (accept) begin
          cnt_d = '0;
          if (cmd_write) begin
            state_d   = StWrAwW;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = cmd_addr;
            wdata_d   = cmd_wdata;
            wstrb_d   = cmd_wstrb;
          end else begin
            state_d   = StRdAr;
            arvalid_d = 1'b1;
            araddr_d  = cmd_addr;
          end
        end
      end

      StWrAwW: begin
        // Each valid drops independently after its own handshake.
        awvalid_d = awvalid_q & ~gc_awready;
        wvalid_d  = wvalid_q & ~gc_wready;
        if (aw_w_complete) begin
          state_d  = StWrB;
          bready_d = 1'b1;
          cnt_d    = '0;
        end else if (phase_expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StWrB: begin
        if (gc_bvalid) begin
          state_d       = StRsp;
          bready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = '0;
          rsp_resp_d    = {gc_bresp, 1'b0};
          rsp_timeout_d = 1'b0;
        end else if (phase_expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StRdAr: begin
        if (gc_arready) begin
          state_d   = StRdR;
          arvalid_d = 1'b0;
          rready_d  = 1'b1;
          cnt_d     = '0;
        end else if (phase_expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StRdR: begin
        if (gc_rvalid) begin
          state_d       = StRsp;
          rready_d      = 1'b0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = gc_rdata;
          rsp_resp_d    = gc_rresp;
          rsp_timeout_d = 1'b0;
        end else if (phase_expired) begin
          abort = 1'b1;
        end else begin
          cnt_d = cnt_q + CntWidth'(1);
        end
      end

      StRsp: begin
        if (rsp_ready) begin
          state_d     = StIdle;
          rsp_valid_d = 1'b0;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    // Timeout abort: drop every channel signal, even mid-handshake, and report SLVERR.
    if (abort) begin
      state_d       = StRsp;
      cnt_d         = '0;
      awvalid_d     = 1'b0;
      wvalid_d      = 1'b0;
      bready_d      = 1'b0;
      arvalid_d     = 1'b0;
      rready_d      = 1'b0;
      rsp_valid_d   = 1'b1;
      rsp_rdata_d   = '0;
      rsp_resp_d    = RespSlvErr;
      rsp_timeout_d = 1'b1;
    end

    // Registered ready: stays low on the first cycle out of reset.
    cmd_ready_d = (state_d == StIdle);
  end

  // State and registered outputs; asynchronous reset clears everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      arvalid_q     <= 1'b0;
      rready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      awaddr_q      <= '0;
      araddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      rsp_rdata_q   <= '0;
      rsp_resp_q    <= '0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      arvalid_q     <= arvalid_d;
      rready_q      <= rready_d;
      rsp_valid_q   <= rsp_valid_d;
      awaddr_q      <= awaddr_d;
      araddr_q      <= araddr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_resp_q    <= rsp_resp_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_resp    = rsp_resp_q;
  assign rsp_timeout = rsp_timeout_q;
  assign gc_awaddr   = awaddr_q;
  assign gc_awvalid  = awvalid_q;
  assign gc_wdata    = wdata_q;
  assign gc_wstrb    = wstrb_q;
  assign gc_wvalid   = wvalid_q;
  assign gc_bready   = bready_q;
  assign gc_araddr   = araddr_q;
  assign gc_arvalid  = arvalid_q;
  assign gc_rready   = rready_q;

endmodule

// File: tb/tb_gc_axil_initiator.sv
// Bench for gc_axil_initiator: directed scenarios plus randomized commands against a
// configurable-latency responder. Expected responses, latencies and per-channel active-cycle
// counts come from a phase-level model and are queued at command acceptance; a monitor pops
// and compares them on each response handshake.

module tb_gc_axil_initiator;

  localparam int T = 8;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        to;
    int          lat;
    int          n_aw;
    int          n_w;
    int          n_b;
    int          n_ar;
    int          n_r;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [11:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic        rsp_timeout;
  logic [11:0] gc_awaddr, gc_araddr;
  logic        gc_awvalid, gc_awready, gc_wvalid, gc_wready;
  logic [31:0] gc_wdata, gc_rdata;
  logic [3:0]  gc_wstrb;
  logic        gc_bvalid, gc_bresp, gc_bready;
  logic        gc_arvalid, gc_arready;
  logic [1:0]  gc_rresp;
  logic        gc_rvalid, gc_rready;

  gc_axil_initiator #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .TIMEOUT   (T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_write  (cmd_write),
    .cmd_addr   (cmd_addr),
    .cmd_wdata  (cmd_wdata),
    .cmd_wstrb  (cmd_wstrb),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_resp   (rsp_resp),
    .rsp_timeout(rsp_timeout),
    .gc_awaddr  (gc_awaddr),
    .gc_awvalid (gc_awvalid),
    .gc_awready (gc_awready),
    .gc_wdata   (gc_wdata),
    .gc_wstrb   (gc_wstrb),
    .gc_wvalid  (gc_wvalid),
    .gc_wready  (gc_wready),
    .gc_bvalid  (gc_bvalid),
    .gc_bresp   (gc_bresp),
    .gc_bready  (gc_bready),
    .gc_araddr  (gc_araddr),
    .gc_arvalid (gc_arvalid),
    .gc_arready (gc_arready),
    .gc_rdata   (gc_rdata),
    .gc_rresp   (gc_rresp),
    .gc_rvalid  (gc_rvalid),
    .gc_rready  (gc_rready)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  exp_t exp_q[$];
  int issued = 0;
  int done_cnt = 0;
  bit expect_b2b = 1'b0;
  bit chain_ok = 1'b0;

  // Responder configuration: cycles each channel waits before completing its handshake.
  int          d_aw = 0, d_w = 0, d_b = 0, d_ar = 0, d_r = 0;
  logic        cfg_bresp = 1'b0;
  logic [31:0] cfg_rdata = '0;
  logic [1:0]  cfg_rresp = '0;
  bit          rsp_rand = 1'b0;
  int          rsp_low_left = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int imin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Phase-level model: each phase lasts (delay+1) cycles unless the delay reaches T, in which
  // case it lasts T cycles and the command ends with a timeout response.
  function automatic exp_t model(input bit wr, input int daw, input int dw, input int db,
                                 input int dar, input int dr, input logic bresp,
                                 input logic [31:0] rdata, input logic [1:0] rresp);
    exp_t e;
    int   first;
    e.rdata = '0; e.resp = 2'b00; e.to = 1'b0; e.lat = 0;
    e.n_aw = 0; e.n_w = 0; e.n_b = 0; e.n_ar = 0; e.n_r = 0;
    if (wr) begin
      e.n_aw = imin(daw + 1, T);
      e.n_w  = imin(dw + 1, T);
      first  = imax(daw, dw);
      if (first >= T) begin
        e.to = 1'b1; e.resp = 2'b10; e.lat = 1 + T;
      end else begin
        e.n_b = imin(db + 1, T);
        if (db >= T) begin
          e.to = 1'b1; e.resp = 2'b10; e.lat = 1 + (first + 1) + T;
        end else begin
          e.resp = {bresp, 1'b0}; e.lat = 1 + (first + 1) + (db + 1);
        end
      end
    end else begin
      e.n_ar = imin(dar + 1, T);
      if (dar >= T) begin
        e.to = 1'b1; e.resp = 2'b10; e.lat = 1 + T;
      end else begin
        e.n_r = imin(dr + 1, T);
        if (dr >= T) begin
          e.to = 1'b1; e.resp = 2'b10; e.lat = 1 + (dar + 1) + T;
        end else begin
          e.rdata = rdata; e.resp = rresp; e.lat = 1 + (dar + 1) + (dr + 1);
        end
      end
    end
    return e;
  endfunction

  // Responder: each ready/valid is driven just after the clock edge from the DUT's settled
  // outputs, counting how many cycles the DUT has been waiting on that channel.
  int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
  initial begin
    gc_awready = 1'b0; gc_wready = 1'b0; gc_bvalid = 1'b0; gc_bresp = 1'b0;
    gc_arready = 1'b0; gc_rvalid = 1'b0; gc_rdata = '0; gc_rresp = '0;
    forever begin
      @(posedge clk); #1;
      if (gc_awvalid) begin gc_awready = (aw_cnt == d_aw); aw_cnt++; end
      else begin gc_awready = 1'b0; aw_cnt = 0; end
      if (gc_wvalid) begin gc_wready = (w_cnt == d_w); w_cnt++; end
      else begin gc_wready = 1'b0; w_cnt = 0; end
      if (gc_arvalid) begin gc_arready = (ar_cnt == d_ar); ar_cnt++; end
      else begin gc_arready = 1'b0; ar_cnt = 0; end
      if (gc_bready) begin gc_bvalid = (b_cnt == d_b); b_cnt++; end
      else begin gc_bvalid = 1'b0; b_cnt = 0; end
      gc_bresp = gc_bvalid ? cfg_bresp : 1'($urandom);
      if (gc_rready) begin gc_rvalid = (r_cnt == d_r); r_cnt++; end
      else begin gc_rvalid = 1'b0; r_cnt = 0; end
      gc_rdata = gc_rvalid ? cfg_rdata : $urandom;
      gc_rresp = gc_rvalid ? cfg_rresp : 2'($urandom);
    end
  end

  // Response-side ready: forced low for a number of valid cycles, random, or always high.
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (rsp_low_left > 0) begin
        rsp_ready = 1'b0;
        if (rsp_valid) rsp_low_left--;
      end else if (rsp_rand) begin
        rsp_ready = ($urandom_range(0, 3) != 0);
      end else begin
        rsp_ready = 1'b1;
      end
    end
  end

  // Monitor: per-command channel activity, response stability, scoreboard compare.
  int          acc_cyc = 0, last_hs_cyc = 0, lat_meas = 0;
  int          m_aw = 0, m_w = 0, m_b = 0, m_ar = 0, m_r = 0;
  bit          seen_rsp = 1'b0, hold_valid = 1'b0;
  logic [31:0] held_rdata;
  logic [1:0]  held_resp;
  logic        held_to;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
        seen_rsp = 1'b0; hold_valid = 1'b0;
      end else begin
        if (cmd_valid && cmd_ready) begin
          if (expect_b2b) chk("b2b_accept_gap", 64'(cyc - last_hs_cyc), 64'(1));
          acc_cyc = cyc; seen_rsp = 1'b0;
          m_aw = 0; m_w = 0; m_b = 0; m_ar = 0; m_r = 0;
        end
        if (gc_awvalid) begin
          m_aw++;
          chk("awaddr_stable", 64'(gc_awaddr), 64'(cmd_addr));
        end
        if (gc_wvalid) begin
          m_w++;
          chk("wdata_stable", 64'({gc_wstrb, gc_wdata}), 64'({cmd_wstrb, cmd_wdata}));
        end
        if (gc_bready) m_b++;
        if (gc_arvalid) begin
          m_ar++;
          chk("araddr_stable", 64'(gc_araddr), 64'(cmd_addr));
        end
        if (gc_rready) m_r++;
        if (hold_valid) begin
          chk("rsp_valid_held", 64'(rsp_valid), 64'(1));
          chk("rsp_fields_held", 64'({rsp_timeout, rsp_resp, rsp_rdata}),
              64'({held_to, held_resp, held_rdata}));
        end
        if (rsp_valid) begin
          chk("cmd_ready_low_in_rsp", 64'(cmd_ready), 64'(0));
          if (!seen_rsp) begin seen_rsp = 1'b1; lat_meas = cyc - acc_cyc; end
          if (rsp_ready) begin
            if (exp_q.size() == 0) begin
              n_cmp++; n_bad++;
              $display("FAIL unexpected_rsp: got response 0x%0h/%0d, want none (t=%0t)",
                       rsp_rdata, rsp_resp, $time);
            end else begin
              e = exp_q.pop_front();
              chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
              chk("rsp_resp", 64'(rsp_resp), 64'(e.resp));
              chk("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
              chk("rsp_latency", 64'(lat_meas), 64'(e.lat));
              chk("aw_w_cycles", 64'({m_aw, m_w}), 64'({e.n_aw, e.n_w}));
              chk("b_cycles", 64'(m_b), 64'(e.n_b));
              chk("ar_r_cycles", 64'({m_ar, m_r}), 64'({e.n_ar, e.n_r}));
            end
            done_cnt++;
            last_hs_cyc = cyc;
            hold_valid = 1'b0;
          end else begin
            hold_valid = 1'b1;
            held_rdata = rsp_rdata; held_resp = rsp_resp; held_to = rsp_timeout;
          end
        end
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (done_cnt != issued && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_cnt != issued) begin
      n_cmp++; n_bad++;
      $display("FAIL rsp_wait_timeout: got %0d responses, want %0d", done_cnt, issued);
      exp_q.delete();
      issued = done_cnt;
    end
  endtask

  // Issue one command; the responder latencies are set before the command is presented.
  task automatic issue(input bit wr, input logic [11:0] addr, input logic [31:0] data,
                       input logic [3:0] strb, input int daw, input int dw, input int db,
                       input int dar, input int dr, input logic bresp,
                       input logic [31:0] rdata, input logic [1:0] rresp, input int gap);
    int k = 0;
    wait_idle();
    for (int g = 0; g < gap; g++) begin @(posedge clk); #1; end
    d_aw = daw; d_w = dw; d_b = db; d_ar = dar; d_r = dr;
    cfg_bresp = bresp; cfg_rdata = rdata; cfg_rresp = rresp;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    expect_b2b = (gap == 0) && chain_ok;
    cmd_valid = 1'b1;
    forever begin
      @(negedge clk);
      if (cmd_ready || k > 50) break;
      k++;
    end
    if (!cmd_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL cmd_accept: got cmd_ready=0 for %0d cycles, want 1", k);
    end else begin
      exp_q.push_back(model(wr, daw, dw, db, dar, dr, bresp, rdata, rresp));
      issued++;
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chain_ok = 1'b1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rsp"}, 64'({rsp_valid, rsp_timeout, rsp_resp, rsp_rdata}), 64'(0));
    chk({tag, "_wr"}, 64'({gc_awaddr, gc_wstrb, gc_wdata}), 64'(0));
    chk({tag, "_ctl"}, 64'({cmd_ready, gc_awvalid, gc_wvalid, gc_bready, gc_araddr,
                            gc_arvalid, gc_rready}), 64'(0));
  endtask

  function automatic int rdelay();
    if ($urandom_range(0, 7) == 0) return int'($urandom_range(T - 1, T + 3));
    return int'($urandom_range(0, 4));
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, want $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge clk); #1;
    check_zero("rst_init");
    reset = 1'b0;
    #2 chk("cmd_ready_pre_edge", 64'(cmd_ready), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("cmd_ready_post_edge", 64'(cmd_ready), 64'(1));
    @(posedge clk); #1;

    // Best-case write, then a delayed read.
    issue(1'b1, 12'h010, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0, 0, 1'b0, '0, 2'b00, 0);
    issue(1'b0, 12'h020, '0, '0, 0, 0, 0, 3, 2, 1'b0, 32'h12345678, 2'b00, 0);
    // W completes well before AW; B returns SLVERR.
    issue(1'b1, 12'h0C4, 32'hA5A5_0F0F, 4'h5, 4, 0, 1, 0, 0, 1'b1, '0, 2'b00, 0);
    // Read with R never arriving.
    issue(1'b0, 12'h030, '0, '0, 0, 0, 0, 0, 50, 1'b0, 32'hFFFF_FFFF, 2'b00, 0);
    // Response held off for 5 cycles, then a back-to-back write.
    rsp_low_left = 5;
    issue(1'b0, 12'h044, '0, '0, 0, 0, 0, 1, 0, 1'b0, 32'hCAFE_F00D, 2'b01, 0);
    issue(1'b1, 12'h048, 32'h0000_1111, 4'h3, 0, 0, 0, 0, 0, 1'b0, '0, 2'b00, 0);
    // Handshakes in the final allowed cycle, then just beyond it.
    issue(1'b1, 12'h100, 32'h7777_8888, 4'hC, T - 1, 2, T - 1, 0, 0, 1'b0, '0, 2'b00, 0);
    issue(1'b0, 12'h104, '0, '0, 0, 0, 0, T - 1, T - 1, 1'b0, 32'h0BAD_C0DE, 2'b11, 0);
    issue(1'b0, 12'h108, '0, '0, 0, 0, 0, T, 0, 1'b0, 32'h1, 2'b00, 0);
    issue(1'b1, 12'h10C, 32'h2, 4'h1, 0, T, 0, 0, 0, 1'b0, '0, 2'b00, 0);
    issue(1'b1, 12'h110, 32'h3, 4'h2, 1, 0, T, 0, 0, 1'b0, '0, 2'b00, 0);

    // Reset while waiting for B: transaction discarded, no response.
    issue(1'b1, 12'h0A4, 32'h5555_AAAA, 4'hF, 0, 0, 20, 0, 0, 1'b0, '0, 2'b00, 0);
    k = 0;
    while (!gc_bready && k < 50) begin @(negedge clk); k++; end
    chk("reach_wr_b", 64'(gc_bready), 64'(1));
    @(posedge clk); #2;
    reset = 1'b1;
    #1 check_zero("rst_mid");
    exp_q.delete();
    issued = done_cnt;
    chain_ok = 1'b0;
    repeat (2) @(posedge clk); #1;
    reset = 1'b0;
    #2 chk("cmd_ready_pre_edge2", 64'(cmd_ready), 64'(0));
    @(posedge clk); @(negedge clk);
    chk("cmd_ready_post_edge2", 64'({cmd_ready, rsp_valid}), 64'(2'b10));
    @(posedge clk); #1;

    // Randomized commands with random latencies and random response back-pressure.
    rsp_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      issue(1'($urandom), 12'($urandom), $urandom, 4'($urandom),
            rdelay(), rdelay(), rdelay(), rdelay(), rdelay(),
            1'($urandom), $urandom, 2'($urandom),
            ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
